// File: rtl/ofmap_pack_pkg.sv
// Shared definitions for the output-feature-map packer and its psum buffer neighbour.
// Holds the controller state encoding, default datapath sizes and the requant clamp value.
package ofmap_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int DATA_W_DEF     = 25;
    localparam int OUT_W_DEF      = 8;
    localparam int PACK_DEF       = 4;
    localparam int FIFO_DEPTH_DEF = 4;

    function automatic int sat_limit(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int SAT_LIMIT = sat_limit(OUT_W_DEF);

endpackage

// File: rtl/ofmap_word_fifo.sv
// Small synchronous FIFO holding packed output words with their addresses.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module ofmap_word_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the storage is reset because the head entry drives out_data directly and must read as zero after reset; this is only affordable because the queue is a few entries deep.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ofmap_pack.sv
// Requantizes ReLU'd partial sums to OUT_W-bit pixels and packs PACK of them per addressed word.
// Rows never share a word; a word leaves the lane register one cycle after its last pixel lands.
module ofmap_pack
    import ofmap_pack_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int OUT_W      = OUT_W_DEF,
    parameter int PACK       = PACK_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ADDR_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [4:0]            cfg_shift,
    input  logic [7:0]            cfg_row_len,
    input  logic [7:0]            cfg_rows,
    input  logic [ADDR_W-1:0]     cfg_base,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic [OUT_W*PACK-1:0] out_data,
    output logic [ADDR_W-1:0]     out_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);
    localparam int WORD_W = OUT_W * PACK;
    localparam int IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [DATA_W:0] SAT = (DATA_W + 1)'(sat_limit(OUT_W));

    state_e            state;
    logic [4:0]        shift_r;
    logic [7:0]        row_len_r;
    logic [7:0]        rows_r;
    logic [7:0]        pix_cnt;
    logic [7:0]        row_cnt;
    logic [ADDR_W-1:0] addr;

    logic [OUT_W-1:0]  q_reg;
    logic              q_valid;
    logic              q_last;
    logic [WORD_W-1:0] lanes, lanes_nx;
    logic [IDX_W-1:0]  lane_idx, idx_nx;
    logic              word_rdy, rdy_nx;

    logic sample, last_pix, last_row, lanes_empty;
    logic fifo_full, fifo_empty, pop;
    logic [ADDR_W+WORD_W-1:0] fifo_rdata;

    function automatic logic [OUT_W-1:0] requant(input logic [DATA_W-1:0] d, input logic [4:0] sh);
        logic [DATA_W:0] rnd;
        logic [DATA_W:0] sum;
        rnd = (sh != 5'd0) ? ((DATA_W + 1)'(1) << (sh - 5'd1)) : '0;
        sum = ({1'b0, d} + rnd) >> sh;
        return (sum > SAT) ? SAT[OUT_W-1:0] : sum[OUT_W-1:0];
    endfunction

    assign sample      = (state == ST_RUN) && in_valid;
    assign last_pix    = (pix_cnt == row_len_r - 8'd1);
    assign last_row    = (row_cnt == rows_r - 8'd1);
    assign lanes_empty = !q_valid && !word_rdy && (lane_idx == '0);
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            shift_r   <= '0;
            row_len_r <= '0;
            rows_r    <= '0;
            pix_cnt   <= '0;
            row_cnt   <= '0;
            addr      <= '0;
        end else begin
            // NOTE: non-blocking assignments let the job-start branch below override these common updates, since the last scheduled write wins.
            if (word_rdy) addr <= addr + 1'b1;
            if (word_rdy && fifo_full && !pop) overflow <= 1'b1;
            case (state)
                ST_IDLE: if (cfg_start) begin
                    state     <= ST_RUN;
                    busy      <= 1'b1;
                    shift_r   <= cfg_shift;
                    row_len_r <= cfg_row_len;
                    rows_r    <= cfg_rows;
                    pix_cnt   <= '0;
                    row_cnt   <= '0;
                    addr      <= cfg_base;
                    overflow  <= 1'b0;
                end
                ST_RUN: if (sample) begin
                    if (last_pix) begin
                        pix_cnt <= '0;
                        row_cnt <= row_cnt + 8'd1;
                        if (last_row) state <= ST_FLUSH;
                    end else begin
                        pix_cnt <= pix_cnt + 8'd1;
                    end
                end
                ST_FLUSH: if (fifo_empty && lanes_empty) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A finished word sits in the lane register for one cycle while the next row/word starts fresh.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
        lanes_nx = word_rdy ? '0 : lanes;
        idx_nx   = lane_idx;
        rdy_nx   = 1'b0;
        if (q_valid) begin
            lanes_nx[int'(lane_idx)*OUT_W +: OUT_W] = q_reg;
            rdy_nx = q_last || (lane_idx == IDX_W'(PACK - 1));
            idx_nx = rdy_nx ? '0 : lane_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg    <= '0;
            q_valid  <= 1'b0;
            q_last   <= 1'b0;
            lanes    <= '0;
            lane_idx <= '0;
            word_rdy <= 1'b0;
        end else begin
            q_reg    <= requant(in_data, shift_r);
            q_valid  <= sample;
            q_last   <= last_pix;
            lanes    <= lanes_nx;
            lane_idx <= idx_nx;
            word_rdy <= rdy_nx;
        end
    end

    ofmap_word_fifo #(
        .WIDTH(ADDR_W + WORD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (word_rdy),
        .pop  (pop),
        .wdata({addr, lanes}),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rdata[WORD_W-1:0];
    assign out_addr  = fifo_rdata[ADDR_W+WORD_W-1:WORD_W];

endmodule

// File: tb/tb_ofmap_pack.sv
// Directed bench for ofmap_pack: an arithmetic model builds the expected word list per job and
// a negedge monitor scores every handshake and the hold-while-stalled rule against it.
module tb_ofmap_pack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [4:0]  cfg_shift = '0;
    logic [7:0]  cfg_row_len = '0;
    logic [7:0]  cfg_rows = '0;
    logic [15:0] cfg_base = '0;
    logic [24:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [31:0] out_data;
    logic [15:0] out_addr;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        overflow;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } word_t;

    word_t       exp_q[$];
    int          px_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        hold_v = 1'b0;
    logic [47:0] hold_w = '0;

    always #5 clk = ~clk;

    ofmap_pack dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_start  (cfg_start),
        .cfg_shift  (cfg_shift),
        .cfg_row_len(cfg_row_len),
        .cfg_rows   (cfg_rows),
        .cfg_base   (cfg_base),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_q(input int d, input int sh);
        longint v;
        v = longint'(d) + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
        v = v >>> sh;
        return (v > 255) ? 255 : int'(v);
    endfunction

    // Rows start at lane 0; a word closes at lane 3 or at the end of a row.
    task automatic model_job(input int sh, input int row_len, input int rows, input int base);
        int          a;
        int          lane;
        logic [31:0] w;
        a = base;
        w = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < row_len; c++) begin
                lane = c % 4;
                w    = w | (32'(model_q(px_q[r*row_len + c], sh)) << (8 * lane));
                if (lane == 3 || c == row_len - 1) begin
                    exp_q.push_back('{addr: 16'(a), data: w});
                    a = (a + 1) % 65536;
                    w = '0;
                end
            end
        end
    endtask

    task automatic drive_job(input int sh, input int row_len, input int rows, input int base);
        cfg_shift   = 5'(sh);
        cfg_row_len = 8'(row_len);
        cfg_rows    = 8'(rows);
        cfg_base    = 16'(base);
        cfg_start   = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        foreach (px_q[i]) begin
            in_data  = 25'(px_q[i]);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_px(input int first, input int n);
        px_q.delete();
        for (int i = 0; i < n; i++) px_q.push_back(first + i);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && !done; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 64'(done), 64'd0);
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) check("hold_stable", 64'({out_addr, out_data}), 64'(hold_w));
            hold_v = out_valid && !out_ready;
            hold_w = {out_addr, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h, expected none", out_addr, out_data);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    check("word_data", 64'(out_data), 64'(w.data));
                    check("word_addr", 64'(out_addr), 64'(w.addr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #7;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        #6 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic pack with exact latency from the last sampled pixel.
        fill_px(1, 4);
        model_job(0, 4, 1, 16'h10);
        check("model_basic", 64'(exp_q[0].data), 64'h04030201);
        drive_job(0, 4, 1, 16'h10);
        check("basic_busy", 64'(busy), 64'd1);
        check("basic_lat1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("basic_lat2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("basic_lat3", 64'(out_valid), 64'd1);
        check("basic_data", 64'(out_data), 64'h04030201);
        check("basic_addr", 64'(out_addr), 64'h10);
        wait_done("basic");

        // Rounding and saturation.
        px_q.delete();
        px_q.push_back(7);
        px_q.push_back(8);
        px_q.push_back(4095);
        px_q.push_back(24'hFFFFFF);
        model_job(4, 4, 1, 16'h30);
        check("model_round", 64'(exp_q[0].data), 64'hFFFF0100);
        drive_job(4, 4, 1, 16'h30);
        wait_done("round");

        // Partial rows leave upper lanes zero and restart at lane 0.
        fill_px(1, 10);
        model_job(0, 5, 2, 16'h50);
        check("model_part0", 64'(exp_q[0].data), 64'h04030201);
        check("model_part1", 64'(exp_q[1].data), 64'h00000005);
        check("model_part2", 64'(exp_q[2].data), 64'h09080706);
        check("model_part3", 64'({exp_q[3].addr, exp_q[3].data}), 64'h0053_0000000A);
        drive_job(0, 5, 2, 16'h50);
        wait_done("partial");

        // Backpressure: words 5 and 6 dropped, addresses wrap past 0xFFFF.
        out_ready = 1'b0;
        fill_px(1, 24);
        model_job(0, 24, 1, 16'hFFFE);
        exp_q.delete(5);
        exp_q.delete(4);
        drive_job(0, 24, 1, 16'hFFFE);
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_valid", 64'(out_valid), 64'd1);
        check("bp_head_data", 64'(out_data), 64'h04030201);
        check("bp_head_addr", 64'(out_addr), 64'hFFFE);
        repeat (3) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done("bp");
        check("bp_overflow_sticky", 64'(overflow), 64'd1);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Full queue with simultaneous push and pop keeps every word.
        out_ready = 1'b0;
        fill_px(1, 20);
        model_job(0, 20, 1, 16'h100);
        drive_job(0, 20, 1, 16'h100);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("fullpop");
        check("fullpop_no_overflow", 64'(overflow), 64'd0);
        check("fullpop_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-job discards the queued word and the next job starts cleanly.
        out_ready = 1'b0;
        fill_px(1, 6);
        drive_job(0, 8, 2, 16'h40);
        check("mid_valid_before_rst", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_data", 64'({out_addr, out_data}), 64'd0);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        fill_px(5, 4);
        model_job(0, 4, 1, 16'h20);
        check("model_restart", 64'({exp_q[0].addr, exp_q[0].data}), 64'h0020_08070605);
        drive_job(0, 4, 1, 16'h20);
        wait_done("restart");
        check("restart_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ofmap_pack.md
OFMAP_PACK -- requirements
Module: ofmap_pack

Interface
REQ-001 Parameters SHALL be: DATA_W, default 25, partial-sum width; OUT_W, default 8, output pixel width; PACK, default 4, pixels per output word; FIFO_DEPTH, default 4, output word queue depth; ADDR_W, default 16, word address width.
REQ-002 Ports SHALL be:
- clk, in, 1, clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- cfg_start, in, 1, one-cycle job start pulse.
- cfg_shift, in, 5, requantization right-shift.
- cfg_row_len, in, 8, pixels per row (1..255).
- cfg_rows, in, 8, rows per job (1..255).
- cfg_base, in, ADDR_W, first word address.
- in_data, in, DATA_W, ReLU'd partial sum (non-negative) from the psum buffer.
- in_valid, in, 1, in_data valid; there is no backpressure toward the source.
- out_data, out, OUT_W*PACK, packed word.
- out_addr, out, ADDR_W, word address.
- out_valid, out, 1, word valid.
- out_ready, in, 1, sink accepts word.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job completion pulse.
- overflow, out, 1, sticky; a word was dropped.

Function
REQ-003 FSM states SHALL be IDLE, RUN, FLUSH and DONE.
- IDLE -> RUN on cfg_start; config is latched and the counters, address and overflow are cleared.
- RUN -> FLUSH after the last pixel of the last row has been accepted.
- FLUSH -> DONE when the queue is empty and the lane register is empty.
- DONE -> IDLE after one cycle.
REQ-004 cfg_start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside RUN.
REQ-005 Requantization SHALL compute q = (in_data + (cfg_shift>0 ? 2^(cfg_shift-1) : 0)) >> cfg_shift, evaluated in DATA_W+1 bits, saturated to 2^OUT_W-1.
REQ-006 Quantization SHALL be one registered stage; a pixel sampled at edge t occupies its lane at edge t+1.
REQ-007 Lane packing: pixel k of a word SHALL occupy bits [8k+7:8k], with lane 0 being the first pixel in time.
REQ-008 A word SHALL be pushed into the queue when:
- lane PACK-1 is filled, or
- the last pixel of a row is placed; unfilled upper lanes are zero, and each row starts at lane 0.
REQ-009 Latency: for a completed word, out_valid SHALL assert 2 cycles after the edge that sampled its last pixel, provided the queue was empty.
REQ-010 out_addr SHALL start at cfg_base and increment by 1 per pushed word, wrapping modulo 2^ADDR_W.
REQ-011 The handshake SHALL complete on out_valid & out_ready; out_data and out_addr SHALL hold stable while out_valid & ~out_ready.
REQ-012 Queue full with push only: the word SHALL be dropped, its address still consumed, and overflow set.
REQ-013 Queue full with push and pop in the same cycle: the push SHALL be accepted, with no overflow.
REQ-014 busy SHALL be high in RUN and FLUSH; done SHALL be high only in DONE.
REQ-015 Counters: pixel count SHALL wrap at cfg_row_len and increment the row count; the row count reaching cfg_rows SHALL end RUN.

Reset
REQ-016 rst_n low SHALL asynchronously force:
- the FSM to IDLE;
- all counters, lanes and the queue to empty/zero;
- out_valid, busy, done and overflow to 0;
- out_data and out_addr to 0.
REQ-017 Reset mid-job SHALL discard all queued words, with no partial completion.

Structure
REQ-018 The shared package SHALL hold:
- the FSM state enum;
- DATA_W, OUT_W, PACK and FIFO_DEPTH defaults, shared with the psum buffer;
- the saturation limit constant.
REQ-019 The word queue SHALL be a separate sub-module, ofmap_word_fifo, a synchronous FIFO of width OUT_W*PACK+ADDR_W with full and empty outputs.

Verification
REQ-020 Basic pack:
- Stimulus: shift=0, row_len=4, rows=1, base=0x10; in_data 1,2,3,4 on consecutive cycles; out_ready=1.
- Required: out_data=0x04030201, out_addr=0x10, out_valid 2 cycles after pixel 4; done follows.
REQ-021 Rounding/saturation:
- Stimulus: shift=4; inputs 7, 8, 4095, 24'hFFFFFF.
- Required: lanes 0, 1, 0xFF, 0xFF, giving word 0xFFFF0100.
REQ-022 Partial row:
- Stimulus: row_len=5, rows=2, shift=0; pixels 1..10.
- Required: 4 words:
  - 0x04030201 at base;
  - 0x00000005 at base+1;
  - 0x09080706 at base+2;
  - 0x0000000A at base+3.
REQ-023 Backpressure/overflow:
- Stimulus: out_ready=0; 24 pixels with row_len=24.
- Required: 4 words queued; words 5 and 6 dropped; overflow=1; the head word is held stable; after out_ready=1, 4 words drain with addresses base..base+3.
REQ-024 Reset mid-job:
- Stimulus: assert rst_n low after 6 pixels.
- Required: out_valid, busy, overflow and done go to 0 immediately; a new cfg_start runs cleanly from cfg_base.
